// File: rtl/eth_fcs_frame_fifo_128b.sv
// Ethernet FCS check/strip stage with a store-and-forward frame FIFO on 128-bit AXI4-Stream.
// Good frames are released whole. Frames with a bad FCS or too many words are dropped whole.
module eth_fcs_frame_fifo_128b #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] s_tdata,
  input  logic [15:0]  s_tkeep,
  input  logic         s_tvalid,
  output logic         s_tready,
  input  logic         s_tlast,
  output logic [127:0] m_tdata,
  output logic [15:0]  m_tkeep,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic         m_tlast,
  output logic         m_tuser,
  output logic         bad_frame,
  output logic         overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

  // Reflected CRC-32 advanced over all 16 bytes of a beat, byte 0 first.
  function automatic logic [31:0] crc32_beat(input logic [31:0] crc_in, input logic [127:0] data);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 16; i++) begin
      c = c ^ 32'(data[8*i +: 8]);
      for (int j = 0; j < 8; j++) begin
        c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
    end
    return c;
  endfunction

  logic [127:0]  mem_data [DEPTH];
  logic          mem_last [DEPTH];

  logic [31:0]   crc_q, crc_d;
  logic          hold_valid_q, hold_valid_d;
  logic [127:0]  hold_data_q, hold_data_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          oversize_q, oversize_d;
  logic          s_tready_d;
  logic          m_tvalid_d, m_tlast_d;
  logic          bad_frame_d, overflow_d;
  logic          accept, fcs_mismatch, we, load;
  logic          unused_tkeep;

  assign unused_tkeep = ^s_tkeep;
  assign m_tkeep      = 16'hFFFF;
  assign m_tuser      = 1'b0;

  assign accept       = s_tvalid && s_tready;
  assign fcs_mismatch = (~crc_q) != s_tdata[31:0];

  // Next-state: CRC, holding register, write/commit/read pointers, output stage and pulses.
  always_comb begin
    crc_d        = crc_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    oversize_d   = oversize_q;
    m_tvalid_d   = m_tvalid;
    m_tlast_d    = m_tlast;
    bad_frame_d  = 1'b0;
    overflow_d   = 1'b0;
    we           = 1'b0;
    load         = 1'b0;

    if (accept) begin
      crc_d = s_tlast ? CRC_INIT : crc32_beat(crc_q, s_tdata);

      // The held word goes to the FIFO only once we know whether it ends the frame.
      if (hold_valid_q && !oversize_q) begin
        if (s_tlast && fcs_mismatch) begin
          wr_ptr_d    = commit_ptr_q;
          bad_frame_d = 1'b1;
        end else begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
          if (s_tlast) begin
            commit_ptr_d = wr_ptr_d;
          end else if ((wr_ptr_d - commit_ptr_q) == PW'(DEPTH)) begin
            // Frame alone fills the FIFO; keep accepting so it can be flushed at its end.
            oversize_d = 1'b1;
          end
        end
      end

      if (s_tlast) begin
        hold_valid_d = 1'b0;
        if (oversize_q) begin
          wr_ptr_d   = commit_ptr_q;
          oversize_d = 1'b0;
          overflow_d = 1'b1;
        end
      end else begin
        hold_valid_d = 1'b1;
        hold_data_d  = s_tdata;
      end
    end

    // Output register refills from committed words only.
    load = (!m_tvalid || m_tready) && (commit_ptr_q != rd_ptr_q);
    if (load) begin
      m_tvalid_d = 1'b1;
      m_tlast_d  = mem_last[rd_ptr_q[AW-1:0]];
      rd_ptr_d   = rd_ptr_q + PW'(1);
    end else if (m_tready) begin
      m_tvalid_d = 1'b0;
    end

    s_tready_d = ((wr_ptr_d - rd_ptr_d) != PW'(DEPTH)) || oversize_d;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q        <= CRC_INIT;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      oversize_q   <= 1'b0;
      s_tready     <= 1'b1;
      m_tvalid     <= 1'b0;
      m_tlast      <= 1'b0;
      bad_frame    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      crc_q        <= crc_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      oversize_q   <= oversize_d;
      s_tready     <= s_tready_d;
      m_tvalid     <= m_tvalid_d;
      m_tlast      <= m_tlast_d;
      bad_frame    <= bad_frame_d;
      overflow     <= overflow_d;
    end
  end

  // Frame storage and synchronous read into the output data register.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_data[wr_ptr_q[AW-1:0]] <= hold_data_q;
      mem_last[wr_ptr_q[AW-1:0]] <= s_tlast;
    end
    if (load) begin
      m_tdata <= mem_data[rd_ptr_q[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_eth_fcs_frame_fifo_128b.sv
// Self-checking bench for eth_fcs_frame_fifo_128b against a table-driven CRC and queue model.
module tb_eth_fcs_frame_fifo_128b;

  localparam int unsigned DEPTH = 1024;

  logic         clk;
  logic         rst;
  logic [127:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic         s_tvalid;
  logic         s_tready;
  logic         s_tlast;
  logic [127:0] m_tdata;
  logic [15:0]  m_tkeep;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic         m_tuser;
  logic         bad_frame;
  logic         overflow;

  eth_fcs_frame_fifo_128b #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .bad_frame(bad_frame), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] d;
    logic         l;
  } word_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          bad_cnt = 0;
  int          ovf_cnt = 0;
  int          rmode = 0;      // 0: ready high, 1: ready low, 2: random ready
  word_t       exp_q[$];
  word_t       got_q[$];
  logic [31:0] crc_tbl [0:255];
  logic [127:0] frm [0:2047];

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [31:0] model_fcs(input int n);
    logic [31:0]  c;
    logic [127:0] w;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      w = frm[i];
      for (int b = 0; b < 16; b++) c = crc_tbl[c[7:0] ^ w[8*b +: 8]] ^ (c >> 8);
    end
    return ~c;
  endfunction

  task automatic make_frame(input int n, output logic [31:0] fcs);
    for (int i = 0; i < n; i++) frm[i] = rand128();
    fcs = model_fcs(n);
  endtask

  task automatic send_beat(input logic [127:0] d, input logic last, input int unblock_at, output int waited);
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (s_tready === 1'b1) break;
      waited++;
      if (unblock_at > 0 && waited == unblock_at) rmode = 2;
      if (waited > 5000) begin
        n_cmp++; n_err++;
        $display("FAIL send_timeout: s_tready low for %0d cycles, expected acceptance", waited);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "input stuck");
      end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic corrupt, output int stalls);
    logic [31:0] fcs;
    int w;
    make_frame(n, fcs);
    if (corrupt) fcs[0] = ~fcs[0];
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      send_beat(frm[i], 1'b0, 0, w);
      stalls += w;
    end
    send_beat({rand128() >> 32, fcs}, 1'b1, 0, w);
    stalls += w;
    if (!corrupt && n >= 1 && n <= int'(DEPTH))
      for (int i = 0; i < n; i++) exp_q.push_back({frm[i], i == n - 1});
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((got_q.size() < exp_q.size() || m_tvalid === 1'b1) && t < 20000) begin
      @(posedge clk); t++;
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  // Output monitor: records transfers, checks stability under stall, counts pulses.
  initial begin
    logic prev_stall;
    logic [127:0] pd;
    logic pl;
    prev_stall = 1'b0;
    pd = '0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          n_cmp++;
          if (m_tvalid !== 1'b1 || m_tdata !== pd || m_tlast !== pl) begin
            n_err++;
            $display("FAIL stall_stable: got v=%b d=%h l=%b, required v=1 d=%h l=%b", m_tvalid, m_tdata, m_tlast, pd, pl);
          end
        end
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
          got_q.push_back({m_tdata, m_tlast});
          n_cmp++;
          if (m_tkeep !== 16'hFFFF || m_tuser !== 1'b0) begin
            n_err++;
            $display("FAIL keep_user: got tkeep=%h tuser=%b, required FFFF/0", m_tkeep, m_tuser);
          end
        end
        prev_stall = (m_tvalid === 1'b1) && (m_tready === 1'b0);
        pd = m_tdata;
        pl = m_tlast;
        if (bad_frame === 1'b1) bad_cnt++;
        if (overflow === 1'b1) ovf_cnt++;
      end
    end
  end

  // Output ready driver.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'b0;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({m_tvalid, m_tlast, bad_frame, overflow} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_outputs: got v/l/bad/ovf=%b, required 0000", {m_tvalid, m_tlast, bad_frame, overflow});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (s_tready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b, required 1", s_tready); end
    n_cmp++;
    if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_mvalid: got %b, required 0", m_tvalid); end
    n_cmp++;
    if (m_tkeep !== 16'hFFFF || m_tuser !== 1'b0) begin
      n_err++; $display("FAIL reset_keep_user: got %h/%b, required FFFF/0", m_tkeep, m_tuser);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int st, b0;
    rmode = 0; b0 = bad_cnt;
    send_frame(3, 1'b0, st);
    wait_drain();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL basic_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL basic_word%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++;
    if (bad_cnt != b0) begin n_err++; $display("FAIL basic_bad: got %0d pulses, required 0", bad_cnt - b0); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_bad_then_good();
    int st, b0;
    rmode = 0; b0 = bad_cnt;
    send_frame(3, 1'b1, st);
    send_frame($urandom_range(1, 8), 1'b0, st);
    wait_drain();
    n_cmp++;
    if (bad_cnt - b0 != 1) begin n_err++; $display("FAIL bad_pulse: got %0d pulses, required 1", bad_cnt - b0); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL bad_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bad_word%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_stall();
    int st;
    rmode = 1;
    send_frame(6, 1'b0, st);
    repeat (50) @(posedge clk);
    #1;
    n_cmp++;
    if (got_q.size() != 0 || m_tvalid !== 1'b1) begin
      n_err++; $display("FAIL stall_hold: got %0d transfers v=%b, required 0 transfers v=1", got_q.size(), m_tvalid);
    end
    rmode = 2;
    for (int f = 0; f < 4; f++) send_frame($urandom_range(1, 12), 1'b0, st);
    wait_drain();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL stall_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL stall_word%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete();
    rmode = 0;
  endtask

  task automatic test_oversize();
    int st, o0, b0;
    rmode = 0; o0 = ovf_cnt; b0 = bad_cnt;
    send_frame(DEPTH + 5, 1'b0, st);
    n_cmp++;
    if (st != 0) begin n_err++; $display("FAIL ovf_ready: got %0d stall cycles, required 0", st); end
    send_frame(2, 1'b0, st);
    wait_drain();
    n_cmp++;
    if (ovf_cnt - o0 != 1 || bad_cnt != b0) begin
      n_err++; $display("FAIL ovf_pulse: got ovf=%0d bad=%0d, required 1/0", ovf_cnt - o0, bad_cnt - b0);
    end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL ovf_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_word%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_fill();
    logic [31:0] fcs;
    logic seen;
    int w, written;
    rmode = 1; seen = 1'b0;
    for (int f = 0; f < 130; f++) begin
      make_frame(8, fcs);
      for (int i = 0; i < 8; i++) exp_q.push_back({frm[i], i == 7});
      for (int k = 0; k <= 8; k++) begin
        if (k < 8) send_beat(frm[k], 1'b0, 30, w);
        else       send_beat({rand128() >> 32, fcs}, 1'b1, 30, w);
        if (w > 0 && !seen) begin
          seen = 1'b1;
          written = f * 8 + ((k > 0) ? k - 1 : 0);
          n_cmp++;
          if (written < int'(DEPTH) || written > int'(DEPTH) + 2) begin
            n_err++; $display("FAIL fill_point: ready dropped after %0d words, required %0d..%0d", written, DEPTH, DEPTH + 2);
          end
        end
      end
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL fill_backpressure: got no stall, required s_tready low at full"); end
    rmode = 2;
    wait_drain();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL fill_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL fill_word%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete();
    rmode = 0;
  endtask

  task automatic test_single_and_reset();
    logic [31:0] fcs;
    int st, w, b0, o0;
    rmode = 0; b0 = bad_cnt; o0 = ovf_cnt;
    send_beat(rand128(), 1'b1, 0, w);
    send_frame(2, 1'b0, st);
    make_frame(5, fcs);
    for (int i = 0; i < 3; i++) send_beat(frm[i], 1'b0, 0, w);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL midreset_valid: got %b, required 0", m_tvalid); end
    got_q.delete(); exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    send_frame(4, 1'b0, st);
    wait_drain();
    n_cmp++;
    if (bad_cnt != b0 || ovf_cnt != o0) begin
      n_err++; $display("FAIL single_pulses: got bad=%0d ovf=%0d, required 0/0", bad_cnt - b0, ovf_cnt - o0);
    end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL reset_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL reset_word%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_single_beat();
    int w, st;
    rmode = 0;
    send_beat(rand128(), 1'b1, 0, w);
    send_frame(3, 1'b0, st);
    wait_drain();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL single_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL single_word%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    logic [31:0] c;
    for (int k = 0; k < 256; k++) begin
      c = 32'(k);
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tbl[k] = c;
    end
    test_reset();
    test_basic();
    test_bad_then_good();
    test_stall();
    test_oversize();
    test_fill();
    test_single_beat();
    test_single_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
